// File: rtl/vector_writeback_ctrl_pkg.sv
// Shared constants and types for the vector register file writeback controller.
package vector_writeback_ctrl_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned NUM_VREGS = 32;

    // FSM encodings kept as plain constants for compatibility with older blocks
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HI   = 1'b1;

    // Which source owns the write port in a given cycle
    typedef enum logic [1:0] {
        GrantNone = 2'd0,
        GrantMac  = 2'd1,
        GrantAlu  = 2'd2
    } grant_e;

endpackage

// File: rtl/vector_writeback_ctrl_if.sv
// Result inputs and register file write-port outputs of the writeback controller.
interface vector_writeback_ctrl_if #(
    parameter int unsigned ADDR_W = vector_writeback_ctrl_pkg::ADDR_W,
    parameter int unsigned DATA_W = vector_writeback_ctrl_pkg::DATA_W
);
    logic                    alu_valid;
    logic                    alu_ready;
    logic [ADDR_W-1:0]       alu_addr;
    logic [DATA_W-1:0]       alu_data;

    logic                    mac_valid;
    logic                    mac_ready;
    logic [ADDR_W-1:0]       mac_addr;
    logic [2*DATA_W-1:0]     mac_data;
    logic                    mac_pair;

    logic                    W_En;
    logic [ADDR_W-1:0]       W_Addr;
    logic [DATA_W-1:0]       WR;
    logic                    MANDA_En;
    logic [2*DATA_W-1:0]     M_ALU_Out;

    logic [vector_writeback_ctrl_pkg::NUM_VREGS-1:0] busy_mask;
    logic                    idle;

    // Result producers and register file side
    modport master (
        output alu_valid, alu_addr, alu_data,
        output mac_valid, mac_addr, mac_data, mac_pair,
        input  alu_ready, mac_ready,
        input  W_En, W_Addr, WR, MANDA_En, M_ALU_Out, busy_mask, idle
    );

    // Writeback controller side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mac_valid, mac_addr, mac_data, mac_pair,
        output alu_ready, mac_ready,
        output W_En, W_Addr, WR, MANDA_En, M_ALU_Out, busy_mask, idle
    );

endinterface

// File: rtl/vector_writeback_ctrl_fifo.sv
// In-order FIFO of ALU results; exposes per-slot valid/address for hazard tracking.
module vwb_result_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [ADDR_W-1:0]                 push_addr,
    input  logic [DATA_W-1:0]                 push_data,
    input  logic                              pop,
    output logic [ADDR_W-1:0]                 head_addr,
    output logic [DATA_W-1:0]                 head_data,
    output logic                              full,
    output logic                              empty,
    output logic [FIFO_DEPTH-1:0]             entry_vld,
    output logic [FIFO_DEPTH-1:0][ADDR_W-1:0] entry_addr
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W-1:0]                 wr_ptr_q;
    logic [PTR_W-1:0]                 rd_ptr_q;
    logic [PTR_W:0]                   count_q;
    logic [FIFO_DEPTH-1:0]            vld_q;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] addr_mem_q;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] data_mem_q;
    logic                             do_push;
    logic                             do_pop;

    assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    // Full blocks a push even when a pop happens in the same cycle
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign entry_vld  = vld_q;
    assign entry_addr = addr_mem_q;

    // Pointers, occupancy and per-slot valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (do_push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful where vld_q is set
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem_q[wr_ptr_q] <= push_addr;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/vector_writeback_ctrl.sv
// Orders ALU and MAC results onto the vector register file write port and MANDA latch.
module vector_writeback_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = vector_writeback_ctrl_pkg::DATA_W,
    parameter int unsigned ADDR_W     = vector_writeback_ctrl_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    vector_writeback_ctrl_if.slave   bus
);

    import vector_writeback_ctrl_pkg::*;

    logic                              fifo_push;
    logic                              fifo_pop;
    logic [ADDR_W-1:0]                 fifo_head_addr;
    logic [DATA_W-1:0]                 fifo_head_data;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic [FIFO_DEPTH-1:0]             fifo_vld;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_addr;

    logic [0:0]          state_q, state_d;
    logic                last_mac_q, last_mac_d;
    logic                hold_vld_q, hold_vld_d;
    logic                hold_pair_q, hold_pair_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [2*DATA_W-1:0] hold_data_q, hold_data_d;
    logic [ADDR_W-1:0]   hold_hi_addr;

    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   wr_q, wr_d;
    logic                manda_en_q, manda_en_d;
    logic [2*DATA_W-1:0] m_alu_out_q, m_alu_out_d;

    logic                mac_take;
    grant_e              grant;
    logic [NUM_VREGS-1:0] busy;

    assign bus.alu_ready = !fifo_full && !rst;
    assign bus.mac_ready = !hold_vld_q && !rst;
    assign fifo_push     = bus.alu_valid && bus.alu_ready;
    assign mac_take      = bus.mac_valid && bus.mac_ready;
    assign fifo_pop      = (grant == GrantAlu);
    // Register index wraps 31 -> 0 by truncation
    assign hold_hi_addr  = hold_addr_q + ADDR_W'(1);

    vwb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_addr  (bus.alu_addr),
        .push_data  (bus.alu_data),
        .pop        (fifo_pop),
        .head_addr  (fifo_head_addr),
        .head_data  (fifo_head_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .entry_vld  (fifo_vld),
        .entry_addr (fifo_addr)
    );

    // Arbitration: MAC and ALU alternate when both are waiting
    always_comb begin
        grant = GrantNone;
        if (state_q == S_IDLE) begin
            if (hold_vld_q && !fifo_empty) begin
                grant = last_mac_q ? GrantAlu : GrantMac;
            end else if (hold_vld_q) begin
                grant = GrantMac;
            end else if (!fifo_empty) begin
                grant = GrantAlu;
            end
        end
    end

    // Next-state for FSM, MAC hold register and write-port outputs
    always_comb begin
        state_d     = state_q;
        last_mac_d  = last_mac_q;
        hold_vld_d  = hold_vld_q;
        hold_pair_d = hold_pair_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        w_en_d      = 1'b0;
        manda_en_d  = 1'b0;
        w_addr_d    = w_addr_q;
        wr_d        = wr_q;
        m_alu_out_d = m_alu_out_q;

        // mac_ready implies the hold is empty, so capture never collides with a clear
        if (mac_take) begin
            hold_vld_d  = 1'b1;
            hold_pair_d = bus.mac_pair;
            hold_addr_d = bus.mac_addr;
            hold_data_d = bus.mac_data;
        end

        if (state_q == S_HI) begin
            w_en_d     = 1'b1;
            w_addr_d   = hold_hi_addr;
            wr_d       = hold_data_q[2*DATA_W-1:DATA_W];
            hold_vld_d = 1'b0;
            state_d    = S_IDLE;
        end else begin
            unique case (grant)
                GrantMac: begin
                    manda_en_d  = 1'b1;
                    m_alu_out_d = hold_data_q;
                    last_mac_d  = 1'b1;
                    if (hold_pair_q) begin
                        w_en_d   = 1'b1;
                        w_addr_d = hold_addr_q;
                        wr_d     = hold_data_q[DATA_W-1:0];
                        state_d  = S_HI;
                    end else begin
                        hold_vld_d = 1'b0;
                    end
                end
                GrantAlu: begin
                    w_en_d     = 1'b1;
                    w_addr_d   = fifo_head_addr;
                    wr_d       = fifo_head_data;
                    last_mac_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; reset discards any unissued high half
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_mac_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_pair_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            wr_q        <= '0;
            manda_en_q  <= 1'b0;
            m_alu_out_q <= '0;
        end else begin
            state_q     <= state_d;
            last_mac_q  <= last_mac_d;
            hold_vld_q  <= hold_vld_d;
            hold_pair_q <= hold_pair_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            wr_q        <= wr_d;
            manda_en_q  <= manda_en_d;
            m_alu_out_q <= m_alu_out_d;
        end
    end

    // Pending-write mask; the low half of a pair drops once it has been issued
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i]) begin
                busy[fifo_addr[i]] = 1'b1;
            end
        end
        if (hold_vld_q && hold_pair_q) begin
            if (state_q == S_IDLE) begin
                busy[hold_addr_q] = 1'b1;
            end
            busy[hold_hi_addr] = 1'b1;
        end
    end

    assign bus.busy_mask = busy;
    assign bus.idle      = fifo_empty && !hold_vld_q && (state_q == S_IDLE);
    assign bus.W_En      = w_en_q;
    assign bus.W_Addr    = w_addr_q;
    assign bus.WR        = wr_q;
    assign bus.MANDA_En  = manda_en_q;
    assign bus.M_ALU_Out = m_alu_out_q;

endmodule

// File: tb/tb_vector_writeback_ctrl.sv
// Randomized self-checking bench with a queue-based reference model of the writeback rules.
module tb_vector_writeback_ctrl;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    vector_writeback_ctrl_if bus ();

    vector_writeback_ctrl #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } alu_beat_t;

    // Reference model state
    alu_beat_t    m_alu[$];
    bit           m_mac_vld;
    bit           m_mac_pair;
    bit           m_hi_due;
    bit           m_last_mac;
    logic [4:0]   m_mac_addr;
    logic [127:0] m_mac_data;

    logic         e_wen;
    logic [4:0]   e_waddr;
    logic [63:0]  e_wr;
    logic         e_men;
    logic [127:0] e_mout;

    bit           saw_alu_stall;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        logic [4:0]  hi;
        m = '0;
        foreach (m_alu[i]) m[m_alu[i].addr] = 1'b1;
        if (m_mac_vld && m_mac_pair) begin
            hi = m_mac_addr + 5'd1;
            if (!m_hi_due) m[m_mac_addr] = 1'b1;
            m[hi] = 1'b1;
        end
        return m;
    endfunction

    // What one rising edge does, given the beats accepted at that edge
    function automatic void model_edge(input bit r, input bit alu_acc, input logic [4:0] aa,
                                       input logic [63:0] ad, input bit mac_acc,
                                       input logic [4:0] ma, input logic [127:0] md,
                                       input bit mp);
        alu_beat_t b;
        bit        take_mac;
        if (r) begin
            m_alu.delete();
            m_mac_vld = 0; m_mac_pair = 0; m_hi_due = 0; m_last_mac = 0;
            e_wen = 0; e_waddr = '0; e_wr = '0; e_men = 0; e_mout = '0;
            return;
        end
        e_wen = 0;
        e_men = 0;
        if (m_hi_due) begin
            e_wen     = 1;
            e_waddr   = m_mac_addr + 5'd1;
            e_wr      = m_mac_data[127:64];
            m_hi_due  = 0;
            m_mac_vld = 0;
        end else begin
            take_mac = m_mac_vld && ((m_alu.size() == 0) || !m_last_mac);
            if (take_mac) begin
                e_men      = 1;
                e_mout     = m_mac_data;
                m_last_mac = 1;
                if (m_mac_pair) begin
                    e_wen    = 1;
                    e_waddr  = m_mac_addr;
                    e_wr     = m_mac_data[63:0];
                    m_hi_due = 1;
                end else begin
                    m_mac_vld = 0;
                end
            end else if (m_alu.size() > 0) begin
                b          = m_alu.pop_front();
                e_wen      = 1;
                e_waddr    = b.addr;
                e_wr       = b.data;
                m_last_mac = 0;
            end
        end
        if (alu_acc) begin
            b.addr = aa;
            b.data = ad;
            m_alu.push_back(b);
        end
        if (mac_acc) begin
            m_mac_vld  = 1;
            m_mac_pair = mp;
            m_mac_addr = ma;
            m_mac_data = md;
        end
    endfunction

    // Drive one cycle of inputs, check readies, step the model, check registered outputs
    task automatic cycle(input bit r, input bit av, input logic [4:0] aa, input logic [63:0] ad,
                         input bit mv, input logic [4:0] ma, input logic [127:0] md,
                         input bit mp);
        bit er;
        bit emr;
        rst           = r;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mac_valid = mv;
        bus.mac_addr  = ma;
        bus.mac_data  = md;
        bus.mac_pair  = mp;
        #1;
        er  = !r && (m_alu.size() < int'(DEPTH));
        emr = !r && !m_mac_vld;
        check("alu_ready", bus.alu_ready, er);
        check("mac_ready", bus.mac_ready, emr);
        if (!r && !bus.alu_ready) saw_alu_stall = 1;
        @(posedge clk);
        model_edge(r, av && er, aa, ad, mv && emr, ma, md, mp);
        #1;
        check("W_En", bus.W_En, e_wen);
        check("W_Addr", bus.W_Addr, e_waddr);
        check("WR", bus.WR, e_wr);
        check("MANDA_En", bus.MANDA_En, e_men);
        check("M_ALU_Out", bus.M_ALU_Out, e_mout);
        check("busy_mask", bus.busy_mask, model_busy());
        check("idle", bus.idle, (m_alu.size() == 0) && !m_mac_vld);
    endtask

    task automatic idle_cycle();
        cycle(0, 0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic rand_cycle(input int rst_odds);
        bit           r;
        logic [4:0]   aa;
        logic [4:0]   ma;
        r  = ($urandom_range(0, rst_odds) == 0);
        // Bias toward a few registers so duplicates and the 31->0 wrap get exercised
        aa = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        ma = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        cycle(r, ($urandom_range(0, 2) != 0), aa, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0), ma, {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 2) != 0));
    endtask

    initial begin
        m_mac_vld = 0; m_mac_pair = 0; m_hi_due = 0; m_last_mac = 0;
        m_mac_addr = '0; m_mac_data = '0;
        e_wen = 0; e_waddr = '0; e_wr = '0; e_men = 0; e_mout = '0;
        saw_alu_stall = 0;

        // Power-up reset
        cycle(1, 0, '0, '0, 0, '0, '0, 0);
        cycle(1, 0, '0, '0, 0, '0, '0, 0);
        idle_cycle();

        // Single ALU write
        cycle(0, 1, 5'd5, 64'h1122334455667788, 0, '0, '0, 0);
        repeat (3) idle_cycle();

        // MAC pair at the top register: high half wraps to register 0
        cycle(0, 0, '0, '0, 1, 5'd31, {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB}, 1);
        repeat (4) idle_cycle();

        // MANDA-only MAC
        cycle(0, 0, '0, '0, 1, 5'd7, {$urandom, $urandom, $urandom, $urandom}, 0);
        repeat (3) idle_cycle();

        // Sustained MAC pairs and back-to-back ALU pushes
        saw_alu_stall = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  1, 5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom}, 1);
        end
        check("alu_backpressure_seen", saw_alu_stall, 1'b1);
        repeat (20) idle_cycle();

        // Reset held two cycles in the middle of traffic
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  1, 5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom}, 1);
        end
        cycle(1, 1, 5'd3, 64'h1, 1, 5'd4, 128'h2, 1);
        cycle(1, 1, 5'd3, 64'h1, 1, 5'd4, 128'h2, 1);
        idle_cycle();

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) rand_cycle(60);
        repeat (20) idle_cycle();

        // Reset while the high half of a pair is still owed
        cycle(0, 0, '0, '0, 1, 5'd12, {$urandom, $urandom, $urandom, $urandom}, 1);
        idle_cycle();
        cycle(1, 0, '0, '0, 0, '0, '0, 0);
        repeat (3) idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
